// File: rtl/id_run_logger_pkg.sv
// Shared definitions for the identifier run-length logger: FSM encoding and
// default sizing constants.
package id_run_logger_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SAT  = 2'd2
  } state_t;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_LW    = 8;

endpackage

// File: rtl/id_run_logger_run_fifo.sv
// First-word-fall-through FIFO of completed run lengths. The head entry is
// presented combinationally; an empty FIFO reads as zero. Pushes into a full
// FIFO are accepted only when a pop happens on the same edge.
module run_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [LW-1:0] din,
  output logic [LW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [LW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so it is not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/id_run_logger.sv
// Measures runs of consecutive enabled id_in=1 samples, queues each completed
// run length into a small FIFO, counts completed runs and flags lost runs.
module id_run_logger
  import id_run_logger_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LW    = DEF_LW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_in,
  input  logic          en,
  input  logic          rd_en,
  output logic [LW-1:0] len_out,
  output logic          empty,
  output logic          full,
  output logic [15:0]   run_cnt,
  output logic          drop
);

  localparam logic [LW-1:0] LEN_MAX = '1;
  localparam logic [LW-1:0] LEN_ONE = LW'(1);

  state_t        state;
  state_t        state_nx;
  logic [LW-1:0] cur_len;
  logic [LW-1:0] len_nx;
  logic          push;

  // Run tracker state and length register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cur_len <= '0;
    end else begin
      state   <= state_nx;
      cur_len <= len_nx;
    end
  end

  // Next-state and push decision; nothing moves on disabled cycles.
  always_comb begin
    state_nx = state;
    len_nx   = cur_len;
    push     = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (id_in) begin
            len_nx   = LEN_ONE;
            state_nx = (LEN_ONE == LEN_MAX) ? SAT : RUN;
          end
        end
        RUN: begin
          if (id_in) begin
            len_nx = cur_len + 1'b1;
            if (len_nx == LEN_MAX) state_nx = SAT;
          end else begin
            push     = 1'b1;
            len_nx   = '0;
            state_nx = IDLE;
          end
        end
        SAT: begin
          if (!id_in) begin
            push     = 1'b1;
            len_nx   = '0;
            state_nx = IDLE;
          end
        end
        default: begin
          len_nx   = '0;
          state_nx = IDLE;
        end
      endcase
    end
  end

  // Completed-run counter and sticky loss flag; a full FIFO can still accept
  // a push when the head is popped on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt <= '0;
      drop    <= 1'b0;
    end else if (push) begin
      run_cnt <= run_cnt + 1'b1;
      if (full && !rd_en) drop <= 1'b1;
    end
  end

  run_fifo #(
    .DEPTH(DEPTH),
    .LW   (LW)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (rd_en),
    .din  (cur_len),
    .dout (len_out),
    .empty(empty),
    .full (full)
  );

endmodule

// File: tb/tb_id_run_logger.sv
// Directed bench for id_run_logger with default DEPTH=4, LW=8.
module tb_id_run_logger;
  import id_run_logger_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_in;
  logic        en;
  logic        rd_en;
  logic [7:0]  len_out;
  logic        empty;
  logic        full;
  logic [15:0] run_cnt;
  logic        drop;

  int passed = 0;
  int total  = 0;

  id_run_logger #(.DEPTH(4), .LW(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .id_in  (id_in),
    .en     (en),
    .rd_en  (rd_en),
    .len_out(len_out),
    .empty  (empty),
    .full   (full),
    .run_cnt(run_cnt),
    .drop   (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Apply one sample, clock it, then settle 1ns past the edge.
  task automatic step(input logic i, input logic e, input logic r);
    id_in = i;
    en    = e;
    rd_en = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    id_in = 1'b0;
    en    = 1'b0;
    rd_en = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_len", 32'(len_out), 0);
    chk("rst_cnt", 32'(run_cnt), 0);
    chk("rst_drop", 32'(drop), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic run of three
    step(0, 1, 0); step(1, 1, 0); step(1, 1, 0); step(1, 1, 0); step(0, 1, 0);
    chk("basic_len", 32'(len_out), 3);
    chk("basic_cnt", 32'(run_cnt), 1);
    chk("basic_empty", 32'(empty), 0);
    step(0, 1, 1);
    chk("basic_pop_empty", 32'(empty), 1);
    chk("basic_pop_len", 32'(len_out), 0);

    // Run spanning disabled cycles
    step(1, 1, 0); step(1, 1, 0);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("gap_no_push", 32'(empty), 1);
    step(1, 1, 0); step(0, 1, 0);
    chk("gap_len", 32'(len_out), 3);
    chk("gap_cnt", 32'(run_cnt), 2);
    step(0, 1, 1);
    chk("gap_pop_empty", 32'(empty), 1);

    // Five runs 1..5 into a depth-4 FIFO
    for (int n = 1; n <= 5; n++) begin
      repeat (n) step(1, 1, 0);
      step(0, 1, 0);
      if (n == 4) begin
        chk("fill4_full", 32'(full), 1);
        chk("fill4_drop", 32'(drop), 0);
      end
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_drop", 32'(drop), 1);
    chk("fill_cnt", 32'(run_cnt), 7);
    for (int n = 1; n <= 4; n++) begin
      chk("fill_head", 32'(len_out), 32'(n));
      step(0, 1, 1);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_len", 32'(len_out), 0);
    chk("drain_drop_sticky", 32'(drop), 1);
    step(0, 1, 1);
    chk("pop_on_empty", 32'(empty), 1);
    chk("pop_on_empty_full", 32'(full), 0);

    // Asynchronous reset during a run at length 5
    repeat (5) step(1, 1, 0);
    reset = 1'b1;
    #1;
    chk("async_empty", 32'(empty), 1);
    chk("async_cnt", 32'(run_cnt), 0);
    chk("async_drop", 32'(drop), 0);
    chk("async_len", 32'(len_out), 0);
    #2;
    reset = 1'b0;
    step(0, 1, 0);
    chk("discard_empty", 32'(empty), 1);
    chk("discard_cnt", 32'(run_cnt), 0);

    // Completion coincident with a pop while full
    repeat (4) begin
      step(1, 1, 0);
      step(0, 1, 0);
    end
    chk("coin_pre_full", 32'(full), 1);
    repeat (7) step(1, 1, 0);
    step(0, 1, 1);
    chk("coin_full", 32'(full), 1);
    chk("coin_drop", 32'(drop), 0);
    chk("coin_cnt", 32'(run_cnt), 5);
    for (int n = 0; n < 3; n++) begin
      chk("coin_head1", 32'(len_out), 1);
      step(0, 1, 1);
    end
    chk("coin_tail", 32'(len_out), 7);
    step(0, 1, 1);
    chk("coin_drained", 32'(empty), 1);

    // Saturation after 300 enabled ones
    reset = 1'b1;
    #2;
    reset = 1'b0;
    repeat (254) step(1, 1, 0);
    chk("sat_before", 32'(dut.state), 32'(RUN));
    step(1, 1, 0);
    chk("sat_state", 32'(dut.state), 32'(SAT));
    repeat (45) step(1, 1, 0);
    chk("sat_hold", 32'(dut.state), 32'(SAT));
    step(0, 1, 0);
    chk("sat_len", 32'(len_out), 255);
    chk("sat_cnt", 32'(run_cnt), 1);
    chk("sat_idle", 32'(dut.state), 32'(IDLE));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_run_logger.md
ID_RUN_LOGGER -- requirements
Module: id_run_logger

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning FIFO entry count (power of two, 2..16).
REQ-002 The block SHALL have parameter LW, default 8, meaning run-length width in bits.
REQ-003 The block SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port id_in  input  1  identifier-valid bit from the id_fsm out port.
REQ-006 The block SHALL have port en  input  1  sample enable; id_in ignored when 0.
REQ-007 The block SHALL have port rd_en  input  1  pop request for the FIFO head.
REQ-008 The block SHALL have port len_out  output  LW  FIFO head run length (first-word-fall-through).
REQ-009 The block SHALL have port empty  output  1  FIFO holds zero entries.
REQ-010 The block SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-011 The block SHALL have port run_cnt  output  16  total completed runs, wrapping modulo 2^16.
REQ-012 The block SHALL have port drop  output  1  sticky flag: a completed run was lost to a full FIFO.

Function
REQ-013 FSM states SHALL be IDLE (id_in low), RUN (counting), SAT (length saturated); transitions occur only on cycles with en=1.
REQ-014 IDLE with id_in=1 SHALL go to RUN and load cur_len=1.
REQ-015 RUN with id_in=1 SHALL increment cur_len; reaching 2^LW-1 SHALL go to SAT.
REQ-016 SAT with id_in=1 SHALL hold cur_len at 2^LW-1.
REQ-017 RUN or SAT with id_in=0 SHALL complete the run: push cur_len, increment run_cnt, go to IDLE, clear cur_len.
REQ-018 en=0 SHALL freeze state and cur_len; a run spanning en=0 cycles counts only enabled 1-samples.
REQ-019 A push SHALL be written at the rising edge after the completing sample; run_cnt SHALL update on that same edge.
REQ-020 A push with full=1 and no simultaneous pop SHALL discard the entry, set drop, and still increment run_cnt.
REQ-021 A push and pop on the same edge SHALL both take effect, including when full (occupancy unchanged, no drop).
REQ-022 rd_en with empty=1 SHALL be ignored; len_out SHALL read 0 when empty.
REQ-023 len_out SHALL show the oldest entry combinationally from the register array; a pop advances it on the next edge.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked by a counter of width log2(DEPTH)+1.
REQ-025 drop SHALL stay 1 until reset.

Reset
REQ-026 reset=1 SHALL asynchronously force state IDLE, cur_len=0, pointers and occupancy 0, run_cnt=0, drop=0.
REQ-027 Outputs during and after reset SHALL be empty=1, full=0, len_out=0, run_cnt=0, drop=0.
REQ-028 A run in progress when reset asserts SHALL be discarded, not pushed.
REQ-029 The first enabled sample after reset deassertion SHALL be treated as coming from IDLE.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, SAT=2'd2) and the default DEPTH/LW constants.
REQ-031 The FIFO SHALL be a separate sub-module named run_fifo (parameters DEPTH, LW; ports clk, reset, push, pop, din, dout, empty, full).
REQ-032 Total RTL SHALL be 120-400 lines across both modules.

Verification
REQ-033 en=1, id_in 0,1,1,1,0 -> one push of len_out=3, run_cnt=1, empty=0 after the fifth edge.
REQ-034 Five runs of lengths 1,2,3,4,5 with no reads, DEPTH=4 -> full=1, drop=1, run_cnt=5, pops yield 1,2,3,4 then empty=1.
REQ-035 id_in held 1 for 300 enabled cycles then 0, LW=8 -> pushed len_out=255, state passes through SAT.
REQ-036 FIFO full, rd_en=1 coincident with a run completion of length 7 -> drop stays 0, full stays 1, tail entry is 7.
REQ-037 id_in 1,1 with en=1, then en=0 for 3 cycles (id_in 0), then id_in 1,0 with en=1 -> single push len_out=3.
REQ-038 reset asserted mid-run at cur_len=5 -> no push, empty=1, run_cnt=0 immediately, without a clock edge.
